// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with status, replace-top, sticky errors, high-water mark
// and a flattened top-first view of every entry.
module lifo_stack_param #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 7,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [DATA_W-1:0]         indata,
   input  logic                      pop,
   input  logic                      clr_err,
   output logic [DATA_W-1:0]         outdata,
   output logic                      empty,
   output logic                      full,
   output logic [CNT_W-1:0]          count,
   output logic [CNT_W-1:0]          hwm,
   output logic                      overflow,
   output logic                      underflow,
   output logic [DEPTH*DATA_W-1:0]   dbg_stack
);

   localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_hwm;
   logic              r_ovf;
   logic              r_udf;

   logic              w_empty;
   logic              w_full;
   logic              w_wr_push;
   logic              w_replace;
   logic              w_do_pop;
   logic              w_ovf_evt;
   logic              w_udf_evt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [DATA_W-1:0] w_top;
   logic [DEPTH*DATA_W-1:0] w_dbg;

   function automatic logic [CNT_W-1:0] f_max(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == LP_DEPTH);

   // Push+pop on an empty stack degrades to a plain push; on a non-empty one it replaces the top.
   always_comb begin
      w_wr_push = 1'b0;
      w_replace = 1'b0;
      w_do_pop  = 1'b0;
      w_ovf_evt = 1'b0;
      w_udf_evt = 1'b0;
      w_cnt_nxt = r_count;
      unique case ({push, pop})
         2'b10: begin
            if (w_full) w_ovf_evt = 1'b1;
            else        w_wr_push = 1'b1;
         end
         2'b01: begin
            if (w_empty) w_udf_evt = 1'b1;
            else         w_do_pop  = 1'b1;
         end
         2'b11: begin
            if (w_empty) w_wr_push = 1'b1;
            else         w_replace = 1'b1;
         end
         default: ;
      endcase
      if (w_wr_push)     w_cnt_nxt = r_count + CNT_W'(1);
      else if (w_do_pop) w_cnt_nxt = r_count - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_hwm   <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
         for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
      end else begin
         // Popped slots are zeroed so everything above the top always reads 0.
         for (int j = 0; j < DEPTH; j++) begin
            if (w_wr_push && (CNT_W'(j) == r_count))
               r_mem[j] <= indata;
            else if (w_replace && (CNT_W'(j + 1) == r_count))
               r_mem[j] <= indata;
            else if (w_do_pop && (CNT_W'(j + 1) == r_count))
               r_mem[j] <= '0;
         end
         r_count <= w_cnt_nxt;
         r_hwm   <= clr_err ? w_cnt_nxt : f_max(r_hwm, w_cnt_nxt);
         r_ovf   <= w_ovf_evt | (r_ovf & ~clr_err);
         r_udf   <= w_udf_evt | (r_udf & ~clr_err);
      end
   end

   always_comb begin
      w_top = '0;
      for (int j = 0; j < DEPTH; j++) begin
         if (CNT_W'(j + 1) == r_count) w_top = r_mem[j];
      end
   end

   // Debug slot i shows mem[count-1-i]; slots at or beyond count stay 0.
   always_comb begin
      w_dbg = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if ((CNT_W'(i) < r_count) && (CNT_W'(j + i + 1) == r_count))
               w_dbg[i*DATA_W +: DATA_W] = r_mem[j];
         end
      end
   end

   assign outdata   = w_top;
   assign empty     = w_empty;
   assign full      = w_full;
   assign count     = r_count;
   assign hwm       = r_hwm;
   assign overflow  = r_ovf;
   assign underflow = r_udf;
   assign dbg_stack = w_dbg;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Randomised + directed bench for lifo_stack_param; a queue-based stack model predicts
// post-edge state, a negedge monitor pops and compares each expectation.
module tb_lifo_stack_param;

   localparam int DW = 10;
   localparam int DP = 7;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          clr_err = 1'b0;
   logic [DW-1:0] indata = '0;
   logic [DW-1:0] outdata;
   logic          empty, full, overflow, underflow;
   logic [CW-1:0] count, hwm;
   logic [DP*DW-1:0] dbg_stack;

   typedef struct {
      logic [DW-1:0]    od;
      logic             em;
      logic             fu;
      logic [CW-1:0]    cnt;
      logic [CW-1:0]    hw;
      logic             ov;
      logic             un;
      logic [DP*DW-1:0] dbg;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;

   int   m_stk[$];
   int   m_hwm = 0;
   bit   m_ovf = 0;
   bit   m_udf = 0;

   lifo_stack_param #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst), .push(push), .indata(indata), .pop(pop),
      .clr_err(clr_err), .outdata(outdata), .empty(empty), .full(full),
      .count(count), .hwm(hwm), .overflow(overflow), .underflow(underflow),
      .dbg_stack(dbg_stack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DP*DW-1:0] act,
                      input logic [DP*DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference: a plain queue whose back is the top of the stack.
   task automatic model_step(input bit r, input bit pu, input bit po, input bit cl,
                             input int d);
      bit eo, eu;
      eo = 0;
      eu = 0;
      if (r) begin
         m_stk.delete();
         m_hwm = 0;
         m_ovf = 0;
         m_udf = 0;
         return;
      end
      if (pu && !po) begin
         if (m_stk.size() < DP) m_stk.push_back(d);
         else eo = 1;
      end else if (po && !pu) begin
         if (m_stk.size() > 0) void'(m_stk.pop_back());
         else eu = 1;
      end else if (pu && po) begin
         if (m_stk.size() > 0) m_stk[m_stk.size()-1] = d;
         else m_stk.push_back(d);
      end
      if (cl) begin
         m_ovf = eo;
         m_udf = eu;
         m_hwm = m_stk.size();
      end else begin
         m_ovf = m_ovf | eo;
         m_udf = m_udf | eu;
         if (m_stk.size() > m_hwm) m_hwm = m_stk.size();
      end
   endtask

   function automatic exp_t model_view();
      exp_t e;
      int   n;
      n = m_stk.size();
      e.od  = (n > 0) ? DW'(m_stk[n-1]) : '0;
      e.em  = (n == 0);
      e.fu  = (n == DP);
      e.cnt = CW'(n);
      e.hw  = CW'(m_hwm);
      e.ov  = m_ovf;
      e.un  = m_udf;
      e.dbg = '0;
      for (int i = 0; i < n; i++) e.dbg[i*DW +: DW] = DW'(m_stk[n-1-i]);
      return e;
   endfunction

   task automatic cyc(input bit r, input bit pu, input bit po, input bit cl,
                      input int d);
      @(negedge clk);
      rst     = r;
      push    = pu;
      pop     = po;
      clr_err = cl;
      indata  = pu ? DW'(d) : 'x;
      model_step(r, pu, po, cl, d);
      @(posedge clk);
      #1;
      exp_q.push_back(model_view());
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("outdata",   DP*DW'(outdata),   DP*DW'(mon_e.od));
         chk("empty",     DP*DW'(empty),     DP*DW'(mon_e.em));
         chk("full",      DP*DW'(full),      DP*DW'(mon_e.fu));
         chk("count",     DP*DW'(count),     DP*DW'(mon_e.cnt));
         chk("hwm",       DP*DW'(hwm),       DP*DW'(mon_e.hw));
         chk("overflow",  DP*DW'(overflow),  DP*DW'(mon_e.ov));
         chk("underflow", DP*DW'(underflow), DP*DW'(mon_e.un));
         chk("dbg_stack", dbg_stack,         mon_e.dbg);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pu_w;
      // Reset
      cyc(1, 0, 0, 0, 0);
      // Push 2, 6, idle, pop twice
      cyc(0, 1, 0, 0, 2);
      cyc(0, 1, 0, 0, 6);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      // Fill, then overflow
      for (int k = 1; k <= 8; k++) cyc(0, 1, 0, 0, k);
      cyc(0, 1, 1, 0, 11);
      // Drain, underflow, clear
      for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      // Replace top, then push+pop on empty
      cyc(0, 1, 0, 0, 3);
      cyc(0, 1, 0, 0, 5);
      cyc(0, 1, 1, 0, 9);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 4);
      // Reset mid-burst
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 100 + k);
      cyc(1, 1, 0, 0, 55);
      // Error and clr_err in the same cycle: error wins
      cyc(0, 0, 1, 1, 0);
      // Random traffic with drifting push bias to visit both boundaries
      for (int k = 0; k < 600; k++) begin
         pu_w = ((k / 60) % 2 == 0) ? 70 : 30;
         cyc(($urandom_range(0, 79) == 0),
             ($urandom_range(0, 99) < pu_w),
             ($urandom_range(0, 99) < 100 - pu_w),
             ($urandom_range(0, 19) == 0),
             int'($urandom_range(0, 1023)));
      end
      cyc(0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
